sync_fifo_prog: RTL

Single-clock FIFO for blocks that sit in one clock domain and need no pointer synchronisation. It is the parametrised successor to the async FIFO. It adds an occupancy count, runtime-programmable almost-full/almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags. It buffers datapath words between a producer and a consumer on the same clk.

---
 rtl/sync_fifo_prog.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO with occupancy count, runtime-programmable
//   almost-full / almost-empty thresholds, a read-valid strobe and sticky
//   overflow / underflow error flags. Producer and consumer share clk, so
//   no pointer synchronisation is needed.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  - when defined, the read port is first-word-fall-through:
//                        rData shows mem[rptr] combinationally while not
//                        empty, rValid = ~rEmpty, and rinc pops the shown word.
//                        When undefined, rData/rValid are registered and a
//                        word appears one cycle after the accepted rinc.
//
// Parameters:
//   DATA_SIZE - word width in bits
//   ADDR_SIZE - address bits; DEPTH = 1 << ADDR_SIZE words
//
// Ports:
//   clk          in   clock, all logic on rising edge
//   rst          in   synchronous active-high reset
//   winc         in   write request
//   wData        in   write data
//   rinc         in   read request (pop acknowledge in FWFT mode)
//   rData        out  read data
//   rValid       out  rData holds a newly read word (FWFT: ~rEmpty)
//   wFull        out  count == DEPTH
//   rEmpty       out  count == 0
//   wAlmostFull  out  count >= af_thresh
//   rAlmostEmpty out  count <= ae_thresh
//   count        out  current occupancy, 0..DEPTH
//   af_thresh    in   almost-full threshold, compared unsigned every cycle
//   ae_thresh    in   almost-empty threshold, compared unsigned every cycle
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//   clr_err      in   clears overflow and underflow (a same-cycle set wins)

module sync_fifo_prog #(
  parameter int unsigned DATA_SIZE = 12,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 rValid,
  output logic                 wFull,
  output logic                 rEmpty,
  output logic                 wAlmostFull,
  output logic                 rAlmostEmpty,
  output logic [ADDR_SIZE:0]   count,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int unsigned        DEPTH     = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [ADDR_SIZE-1:0] wptr;
  logic [ADDR_SIZE-1:0] rptr;
  logic [ADDR_SIZE:0]   count_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic                 wr_ok;
  logic                 rd_ok;

  // Flags are pure decodes of the registered count, so they move on the
  // edge after the one that accepted the access.
  assign count        = count_q;
  assign wFull        = (count_q == DEPTH_CNT);
  assign rEmpty       = (count_q == '0);
  assign wAlmostFull  = (count_q >= af_thresh);
  assign rAlmostEmpty = (count_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Full with both requests accepts only the read; empty with both
  // requests accepts only the write. That falls out of gating each side
  // with its own flag.
  assign wr_ok = winc & ~wFull;
  assign rd_ok = rinc & ~rEmpty;

  // Storage has no reset; a write during reset is suppressed so that the
  // discarded word cannot land in the array.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wptr] <= wData;
    end
  end

  // Pointers and occupancy. Pointers carry no wrap bit: count alone tells
  // full from empty when wptr == rptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ADDR_SIZE'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + ADDR_SIZE'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (ADDR_SIZE + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_SIZE + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps
  // the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (winc && wFull) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (rinc && rEmpty) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  // Head word is always on display; rData is meaningless while empty.
  assign rData  = mem[rptr];
  assign rValid = ~rEmpty;

`else

  logic [DATA_SIZE-1:0] rdata_q;
  logic                 rvalid_q;

  // Registered read port: one-cycle latency, rData holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) begin
        rdata_q <= mem[rptr];
      end
    end
  end

  assign rData  = rdata_q;
  assign rValid = rvalid_q;

`endif

endmodule
